uibi_mem_responder: RTL and testbench

UIBI_MEM_RESPONDER -- requirements
Module: uibi_mem_responder

---
 rtl/uibi_mem_responder.sv | 126 ++++++++++++
 tb/tb_uibi_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uibi_mem_responder.sv
// uibi_mem_responder: single-port word memory behind a valid/ready request bus.
// Each accepted request takes one ACCESS cycle, then holds its response until it is taken.
module uibi_mem_responder #(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] BUS_NULL = 3'd0;
  localparam logic [2:0] BUS_QUAR = 3'd1;
  localparam logic [2:0] BUS_HALF = 3'd2;
  localparam logic [2:0] BUS_FULL = 3'd3;

  localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'(DEPTH) << 2);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        wr_q;
  logic [2:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  logic [3:0]    be;
  logic          size_err;
  logic          range_err;
  logic          err_c;
  logic [AW-1:0] idx;

  always_comb begin
    be       = 4'b0000;
    size_err = 1'b0;
    case (size_q)
      BUS_QUAR: be = 4'b0001 << addr_q[1:0];
      BUS_HALF: begin
        be       = 4'b0011 << addr_q[1:0];
        size_err = addr_q[0];
      end
      BUS_FULL: begin
        be       = 4'b1111;
        size_err = addr_q[1:0] != 2'b00;
      end
      default:  size_err = 1'b1;
    endcase
  end

  // 33-bit upper compare so BASE + 4*DEPTH cannot wrap
  assign range_err = (addr_q < BASE) || ({1'b0, addr_q} >= LIMIT);
  assign err_c     = size_err || range_err;
  assign idx       = AW'((addr_q - BASE) >> 2);

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = ACCESS;
      end
      ACCESS: state_nx = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wr_q    <= req_wr;
        size_q  <= req_size;
        wdata_q <= req_wdata;
      end
      if (state == ACCESS) begin
        rdata_q <= (err_c || wr_q) ? 32'h0 : mem[idx];
        err_q   <= err_c;
      end
    end
  end

  // reset wins over a store sitting in ACCESS
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && wr_q && !err_c) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_uibi_mem_responder.sv
// tb_uibi_mem_responder: directed and random requests checked against
// a byte-level reference memory kept in the bench.
module tb_uibi_mem_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  localparam logic [2:0] S_NULL = 3'd0;
  localparam logic [2:0] S_QUAR = 3'd1;
  localparam logic [2:0] S_HALF = 3'd2;
  localparam logic [2:0] S_FULL = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];

  uibi_mem_responder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] addr, input logic wr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rdata);
    longint a  = longint'(addr);
    longint lo = longint'(BASE);
    longint hi = lo + 4 * DEPTH;
    int     n;
    int     w;
    int     lane;
    logic [31:0] word;
    case (size)
      S_QUAR:  n = 1;
      S_HALF:  n = 2;
      S_FULL:  n = 4;
      default: n = 0;
    endcase
    err   = (n == 0) || (a % n != 0) || (a < lo) || (a >= hi);
    rdata = 32'h0;
    if (err) return;
    w = int'((a - lo) / 4);
    word = ref_mem.exists(w) ? ref_mem[w] : 32'hxxxx_xxxx;
    if (wr) begin
      for (int b = 0; b < n; b++) begin
        lane = int'(a % 4) + b;
        word[8*lane +: 8] = wdata[8*lane +: 8];
      end
      ref_mem[w] = word;
    end else begin
      rdata = word;
    end
  endfunction

  task automatic scramble();
    req_addr  = $urandom;
    req_wr    = 1'($urandom);
    req_size  = 3'($urandom);
    req_wdata = $urandom;
    req_valid = 1'($urandom);
  endtask

  task automatic do_req(input string tag, input logic [31:0] addr,
                        input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] got);
    logic        e_err;
    logic [31:0] e_rd;
    model(addr, wr, size, wdata, e_err, e_rd);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wr    = wr;
    req_size  = size;
    req_wdata = wdata;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    scramble();
    chk({tag, ".access_valid"}, 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".err"}, 32'(resp_err), 32'(e_err));
    chk({tag, ".rdata"}, resp_rdata, e_rd);
    got = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      scramble();
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, resp_rdata, e_rd);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          pick;

    rst        = 1'b1;
    req_valid  = 1'b1;
    req_addr   = BASE;
    req_wr     = 1'b1;
    req_size   = S_FULL;
    req_wdata  = 32'hFFFF_FFFF;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.ready", 32'(req_ready), 32'd1);
    chk("reset.valid", 32'(resp_valid), 32'd0);
    chk("reset.rdata", resp_rdata, 32'h0);
    chk("reset.err", 32'(resp_err), 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++)
      do_req("init", BASE + 32'(4 * i), 1'b1, S_FULL, $urandom, 0, got);

    do_req("full_st", 32'h8000_0010, 1'b1, S_FULL, 32'hDEAD_BEEF, 0, got);
    do_req("full_ld", 32'h8000_0010, 1'b0, S_FULL, 32'h0, 0, got);
    chk("full_ld.val", got, 32'hDEAD_BEEF);
    do_req("quar_st", 32'h8000_0013, 1'b1, S_QUAR, 32'h5A00_0000, 0, got);
    do_req("half_st", 32'h8000_0010, 1'b1, S_HALF, 32'h0000_1234, 0, got);
    do_req("lane_ld", 32'h8000_0010, 1'b0, S_FULL, 32'h0, 0, got);
    chk("lane_ld.val", got, 32'h5AAD_1234);

    do_req("half_mis", 32'h8000_0011, 1'b1, S_HALF, 32'hFFFF_FFFF, 0, got);
    do_req("full_mis", 32'h8000_0012, 1'b1, S_FULL, 32'hFFFF_FFFF, 0, got);
    do_req("above", BASE + 32'(4 * DEPTH), 1'b1, S_FULL, 32'hFFFF_FFFF, 0, got);
    do_req("below", 32'h7FFF_FFFC, 1'b0, S_FULL, 32'h0, 0, got);
    do_req("null_wr", 32'h8000_0010, 1'b1, S_NULL, 32'hFFFF_FFFF, 0, got);
    do_req("bad_code", 32'h8000_0010, 1'b1, 3'd6, 32'hFFFF_FFFF, 0, got);
    do_req("after_err", 32'h8000_0010, 1'b0, S_FULL, 32'h0, 0, got);
    chk("after_err.val", got, 32'h5AAD_1234);

    do_req("top_st", BASE + 32'(4 * DEPTH - 4), 1'b1, S_FULL, 32'hCAFE_F00D, 0, got);
    do_req("top_ld", BASE + 32'(4 * DEPTH - 4), 1'b0, S_HALF, 32'h0, 0, got);
    chk("top_ld.val", got, 32'hCAFE_F00D);

    do_req("bp_ld", 32'h8000_0010, 1'b0, S_QUAR, 32'h0, 5, got);
    chk("bp_ld.val", got, 32'h5AAD_1234);

    do_req("zero_st", 32'h8000_0020, 1'b1, S_FULL, 32'h0, 0, got);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0020;
    req_wr    = 1'b1;
    req_size  = S_FULL;
    req_wdata = 32'h1111_1111;
    @(posedge clk); #1;
    req_valid = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    chk("rst_mid.ready", 32'(req_ready), 32'd1);
    chk("rst_mid.rdata", resp_rdata, 32'h0);
    chk("rst_mid.err", 32'(resp_err), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_mid.no_resp", 32'(resp_valid), 32'd0);
    end
    do_req("rst_ld", 32'h8000_0020, 1'b0, S_FULL, 32'h0, 0, got);
    chk("rst_ld.val", got, 32'h0);

    for (int i = 0; i < 80; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 8)       a = BASE + $urandom_range(0, 63);
      else if (pick == 8) a = BASE + 32'(4 * DEPTH) + $urandom_range(0, 7);
      else                a = BASE - 32'd1 - $urandom_range(0, 7);
      do_req("rand", a, 1'($urandom), 3'($urandom_range(0, 4)),
             $urandom, int'($urandom_range(0, 2)), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
